// File: rtl/weight_sram_burst.sv
// Weight SRAM with a burst read port: 1-cycle SRAM read into a 2-entry output FIFO with ready/valid backpressure.
// Optional build macro WSRAM_PARITY_EN stores an even-parity bit per word and flags read parity failures on rd_err.
module weight_sram_burst #(
  parameter int DATA_W = 100,
  parameter int DEPTH  = 20000,
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_err
);

  // state | meaning
  // IDLE  | no burst; rd_req sampled here only
  // ISSUE | reading one address per cycle while the FIFO has room
  // DRAIN | all addresses issued; waiting for the rd_last handshake
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

`ifdef WSRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  state_t state, state_nxt;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  sram_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rem;
  logic              inflight, inflight_last;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic [SUM_W-1:0]  req_end;
  logic              wr_ok, req_live, req_fits, accept, req_bad, issue, pop, push, par_err;

  assign wr_ok    = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign req_end  = SUM_W'(rd_base) + SUM_W'(rd_len);
  assign req_live = rd_req && (rd_len != '0);
  assign req_fits = req_end <= SUM_W'(DEPTH);

  assign rd_valid = (count != 2'd0);
  assign rd_data  = fifo_data[rd_ptr];
  assign rd_last  = rd_valid && fifo_last[rd_ptr];
  assign rd_busy  = (state != IDLE);
  assign pop      = rd_valid && rd_ready;
  assign push     = inflight;
  assign occ      = {1'b0, count} + {2'b00, inflight};

`ifdef WSRAM_PARITY_EN
  assign par_err = ^sram_q;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_bad   = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (req_live && req_fits) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end else if (req_live) begin
          req_bad = 1'b1;
        end
      end
      ISSUE: begin
        // A pop this cycle frees a slot, keeping 1 word/cycle with rd_ready high
        if ((occ < 3'd2) || pop) begin
          issue = 1'b1;
          if (rem == LEN_W'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Memory and read register carry no reset; same-edge write/read returns the old word
  always_ff @(posedge clk) begin
`ifdef WSRAM_PARITY_EN
    if (wr_ok) mem[wr_addr] <= {^wr_data, wr_data};
`else
    if (wr_ok) mem[wr_addr] <= wr_data;
`endif
    if (issue) sram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr       <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (rem == LEN_W'(1));
      if (accept) begin
        rd_addr <= rd_base;
        rem     <= rd_len;
      end else if (issue) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        rem     <= rem - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= sram_q[DATA_W-1:0];
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_err <= 1'b0;
    else if ((wr_en && !wr_ok) || req_bad || (push && par_err)) rd_err <= 1'b1;
  end

endmodule

// File: tb/tb_weight_sram_burst.sv
// Directed self-checking bench for weight_sram_burst: bursts, backpressure, range errors, reset abort, read-first.
// Define WSRAM_PARITY_EN for both files to include the parity-corruption case.
module tb_weight_sram_burst;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [14:0]  wr_addr = '0;
  logic [99:0]  wr_data = '0;
  logic         rd_req = 1'b0;
  logic [14:0]  rd_base = '0;
  logic [10:0]  rd_len = '0;
  logic         rd_busy, rd_valid, rd_last, rd_err;
  logic         rd_ready = 1'b0;
  logic [99:0]  rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [99:0] model [int];

  weight_sram_burst dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_now(input string tag);
    rst = 1'b1;
    rd_req = 1'b0;
    #1;
    chk({tag, "_busy"},  128'(rd_busy),  128'(0));
    chk({tag, "_valid"}, 128'(rd_valid), 128'(0));
    chk({tag, "_last"},  128'(rd_last),  128'(0));
    chk({tag, "_err"},   128'(rd_err),   128'(0));
    chk({tag, "_data"},  128'(rd_data),  128'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_word(input int a, input logic [99:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 15'(a); wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_burst(input string tag, input int base, input int len, input bit toggle,
                           input bit do_wr, input int wa, input logic [99:0] wd);
    int idx = 0;
    int first = -1;
    bit stall = 1'b0;
    logic [99:0] held = '0;
    @(negedge clk);
    rd_req = 1'b1; rd_base = 15'(base); rd_len = 11'(len); rd_ready = 1'b0;
    for (int it = 1; it <= 200 && idx < len; it++) begin
      @(negedge clk);
      rd_req = 1'b0;
      if (do_wr) begin
        wr_en = (it == 1); wr_addr = 15'(wa); wr_data = wd;
      end
      if (stall) begin
        chk({tag, "_stall_valid"}, 128'(rd_valid), 128'(1));
        chk({tag, "_stall_data"},  128'(rd_data),  128'(held));
      end
      rd_ready = toggle ? (it % 2 == 1) : 1'b1;
      if (rd_valid && first < 0) first = it;
      if (rd_valid && rd_ready) begin
        chk({tag, "_data"}, 128'(rd_data), 128'(model[base + idx]));
        chk({tag, "_last"}, 128'(rd_last), 128'(idx == len - 1));
        idx++;
      end
      stall = rd_valid && !rd_ready;
      held  = rd_data;
    end
    chk({tag, "_words"}, 128'(idx), 128'(len));
    if (!toggle) chk({tag, "_first_valid"}, 128'(first), 128'(3));
    @(negedge clk);
    wr_en = 1'b0; rd_ready = 1'b0;
    chk({tag, "_busy_after"},  128'(rd_busy),  128'(0));
    chk({tag, "_valid_after"}, 128'(rd_valid), 128'(0));
    if (do_wr) model[wa] = wd;
  endtask

  task automatic idle_request(input string tag, input int base, input int len, input bit exp_err);
    @(negedge clk);
    rd_req = 1'b1; rd_base = 15'(base); rd_len = 11'(len); rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rd_req = 1'b0;
      chk({tag, "_busy"},  128'(rd_busy),  128'(0));
      chk({tag, "_valid"}, 128'(rd_valid), 128'(0));
    end
    chk({tag, "_err"}, 128'(rd_err), 128'(exp_err));
    rd_ready = 1'b0;
  endtask

  initial begin
    int nv;
    reset_now("reset");

    for (int i = 0; i < 10; i++) write_word(i, 100'(i + 1));
    run_burst("b0_10", 0, 10, 1'b0, 1'b0, 0, '0);
    run_burst("b3_6_toggle", 3, 6, 1'b1, 1'b0, 0, '0);

    idle_request("len0", 0, 0, 1'b0);
    idle_request("range", 19995, 6, 1'b1);

    // Abort a len=8 burst as its third word is presented
    @(negedge clk);
    rd_req = 1'b1; rd_base = 15'(0); rd_len = 11'(8); rd_ready = 1'b1;
    nv = 0;
    for (int it = 0; it < 50 && nv < 3; it++) begin
      @(negedge clk);
      rd_req = 1'b0;
      if (rd_valid) nv++;
    end
    chk("mid_third_seen", 128'(nv), 128'(3));
    reset_now("mid_reset");
    rd_ready = 1'b0;
    run_burst("after_reset", 0, 2, 1'b0, 1'b0, 0, '0);

    for (int i = 19994; i < 20000; i++) write_word(i, 100'(i + 100));
    run_burst("edge_fit", 19994, 6, 1'b0, 1'b0, 0, '0);
    chk("edge_fit_err", 128'(rd_err), 128'(0));

    @(negedge clk);
    wr_en = 1'b1; wr_addr = 15'(20000); wr_data = 100'h5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("bad_write_err", 128'(rd_err), 128'(1));
    @(negedge clk);
    reset_now("reset2");

    run_burst("read_first", 5, 1, 1'b0, 1'b1, 5, 100'hDEAD_BEEF_0123);
    run_burst("reread", 5, 1, 1'b0, 1'b0, 0, '0);
    chk("reread_model", 128'(model[5]), 128'(100'hDEAD_BEEF_0123));

`ifdef WSRAM_PARITY_EN
    @(negedge clk);
    dut.mem[2][100] = ~dut.mem[2][100];
    chk("par_err_before", 128'(rd_err), 128'(0));
    run_burst("parity", 2, 1, 1'b0, 1'b0, 0, '0);
    chk("par_err_after", 128'(rd_err), 128'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_sram_burst.md
WEIGHT_SRAM_BURST -- requirements
Module: weight_sram_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 100: word width in bits (25 weights x 4 b).
REQ-002 SHALL have parameter DEPTH, default 20000: number of words.
REQ-003 SHALL have parameter ADDR_W, default 15: address width; ADDR_W >= clog2(DEPTH).
REQ-004 SHALL have parameter LEN_W, default 11: burst-length field width.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1: write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-009 SHALL have port wr_data, input, DATA_W: write data.
REQ-010 SHALL have port rd_req, input, 1: burst start request, sampled only in IDLE.
REQ-011 SHALL have port rd_base, input, ADDR_W: first burst address.
REQ-012 SHALL have port rd_len, input, LEN_W: number of words in the burst.
REQ-013 SHALL have port rd_busy, output, 1: high when not in IDLE.
REQ-014 SHALL have port rd_valid, output, 1: rd_data is valid.
REQ-015 SHALL have port rd_ready, input, 1: consumer accepts the word when rd_valid & rd_ready.
REQ-016 SHALL have port rd_data, output, DATA_W: read word.
REQ-017 SHALL have port rd_last, output, 1: final word of the burst, qualified by rd_valid.
REQ-018 SHALL have port rd_err, output, 1: sticky error flag (range or parity).

Function
REQ-019 SHALL write mem[wr_addr] <= wr_data on any edge with wr_en=1 and wr_addr < DEPTH; out-of-range writes are dropped and set rd_err.
REQ-020 SHALL use an FSM with states IDLE, ISSUE and DRAIN.
REQ-021 IDLE -> ISSUE on rd_req=1, rd_len != 0 and rd_base+rd_len <= DEPTH; the module latches base and len.
REQ-022 In IDLE, rd_req with rd_len=0 SHALL be ignored; an out-of-range request SHALL set rd_err and stay in IDLE (no wrap-around).
REQ-023 rd_req while not IDLE SHALL be ignored.
REQ-024 SHALL have an SRAM read latency of 1 cycle into a 2-entry output FIFO.
REQ-025 ISSUE SHALL issue one read per cycle while (FIFO occupancy + in-flight reads) < 2.
REQ-026 Throughput SHALL be 1 word/cycle with rd_ready held high; first rd_valid 2 cycles after the accepted rd_req edge.
REQ-027 ISSUE -> DRAIN after the last address is issued; DRAIN -> IDLE on the handshake of the rd_last word.
REQ-028 rd_data/rd_valid SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-029 SHALL rely on rd_ready=0 for backpressure with no data loss; issue stalls, in-flight data lands in the FIFO.
REQ-030 A simultaneous write and burst read of the same address SHALL return the old data (read-first).
REQ-031 A new request SHALL be accepted in the cycle IDLE is re-entered, not earlier.

Reset
REQ-032 SHALL drive rd_busy=0, rd_valid=0, rd_last=0, rd_err=0 and rd_data=0 immediately on rst, leaving the FSM in IDLE with the FIFO empty.
REQ-033 A reset mid-burst SHALL abort the burst and discard FIFO and in-flight words.
REQ-034 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-035 With WSRAM_PARITY_EN defined, the module SHALL store DATA_W+1 bits per word (even parity computed on write); a read word failing the check sets rd_err and the data is still delivered.
REQ-036 Without WSRAM_PARITY_EN, the module SHALL store DATA_W bits per word with no parity, and rd_err reflects only range errors.

Verification
REQ-037 Write words 0..9 = 100'h1..100'hA, burst base=0 len=10 with rd_ready=1 -> 10 consecutive valid words 1..A; rd_last only on A; rd_busy falls after.
REQ-038 Burst base=3 len=6 with rd_ready toggling 1/0 every cycle -> words 4..9 in order, none dropped or duplicated, data stable while stalled.
REQ-039 Request base=19995 len=6 (DEPTH=20000) -> no rd_valid, rd_err=1, rd_busy stays 0; request with len=0 -> no activity.
REQ-040 Assert rst on the 3rd valid word of a len=8 burst -> rd_valid=0 and rd_busy=0 immediately; a following burst base=0 len=2 returns correct words.
REQ-041 Write addr 5 = X during the cycle it is burst-read -> old value returned; a later read returns X.
REQ-042 With WSRAM_PARITY_EN defined, force-flip one stored bit of addr 2, then read it -> rd_err=1 and the word is still delivered.
